// File: rtl/ad7768_rx_pkg.sv
// Shared constants, sync sequencer state type and header helper for the
// AD7768 eight-lane serial receiver.
package ad7768_rx_pkg;

    localparam int         WORD_BITS = 32;
    localparam int         DATA_BITS = 24;
    localparam int         LANES     = 8;
    localparam logic [4:0] HDR_MAGIC = 5'h10;

    // ADC SYNC pulse sequencer states
    typedef enum logic {
        SYNC_IDLE,
        SYNC_PULSE
    } sync_state_t;

    // A word is well-formed when both header fields carry the magic value
    // and the channel number of the lane it arrived on.
    function automatic logic hdr_match(input logic [WORD_BITS-1:0] word,
                                       input logic [2:0]           lane);
        return (word[31:27] == HDR_MAGIC) && (word[26:24] == lane) &&
               (word[23:19] == HDR_MAGIC) && (word[18:16] == lane);
    endfunction

endpackage

// File: rtl/ad7768_rx_lane.sv
// One AD7768 serial lane: shift register, optional header compare and the
// 24-bit sample output register.
// Optional feature macro: AD7768_RX_HDR_CHECK_EN (header compare). When it
// is not defined the compare is not built and hdr_err is tied to 0.
module ad7768_rx_lane
    import ad7768_rx_pkg::*;
`ifdef AD7768_RX_HDR_CHECK_EN
#(
    parameter int LANE = 0
)
`endif
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample,
    input  logic                 load,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] data,
    output logic                 hdr_err
);

    // Without the header check only the low 24 bits of a word are ever
    // used, so the upper bits are not kept at all.
`ifdef AD7768_RX_HDR_CHECK_EN
    localparam int SR_BITS = WORD_BITS;
`else
    localparam int SR_BITS = DATA_BITS;
`endif

    // shreg holds the previously sampled bits; word_next appends the bit
    // being sampled now, so at frame end it is the complete word.
    logic [SR_BITS-2:0] shreg;
    logic [SR_BITS-1:0] word_next;

    assign word_next = {shreg, bit_in};

    // Shift the lane in MSB first on every sample strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg <= '0;
        end else if (sample) begin
            shreg <= word_next[SR_BITS-2:0];
        end
    end

    // Capture the sample field of a complete, correctly counted word
    always_ff @(posedge clock) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= word_next[DATA_BITS-1:0];
        end
    end

`ifdef AD7768_RX_HDR_CHECK_EN
    // Flag a header that does not name this lane's channel
    always_ff @(posedge clock) begin
        if (reset) begin
            hdr_err <= 1'b0;
        end else if (load) begin
            hdr_err <= !hdr_match(word_next, 3'(LANE));
        end
    end
`else
    assign hdr_err = 1'b0;
`endif

endmodule

// File: rtl/ad7768_rx.sv
// AD7768 eight-lane receiver: registers the pins, aligns to DRDY, counts
// bits, tracks lock and drives the active-low ADC SYNC pulse.
// Optional feature macro: AD7768_RX_HDR_CHECK_EN (per-lane header check).
module ad7768_rx
    import ad7768_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int SAMPLE_PHASE = 2,
    parameter int SYNC_CLKS    = 8
)(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [LANES-1:0]           add,
    input  logic                       drdy,
    input  logic                       sync_req,
    output logic                       sync,
    output logic                       ovalid,
    output logic [LANES*DATA_BITS-1:0] odata,
    output logic [LANES-1:0]           hdr_err,
    output logic                       frame_err,
    output logic                       locked
);

    localparam int         PW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int         SW          = (SYNC_CLKS > 1) ? $clog2(SYNC_CLKS) : 1;
    localparam logic [5:0] BITCNT_MAX  = 6'd63;
    localparam logic [5:0] BITCNT_FULL = 6'(WORD_BITS - 1);

    logic [LANES-1:0] add_r;
    logic             drdy_r;
    logic             drdy_q;
    logic [PW-1:0]    phase;
    logic [PW-1:0]    phase_cur;
    logic [5:0]       bitcnt;
    sync_state_t      state;
    logic [SW-1:0]    sync_cnt;
    logic             drdy_rise;
    logic             sample;
    logic             frame_end;
    logic             load;

    // Register the ADC pins once; drdy_q remembers the previous drdy_r
    always_ff @(posedge clock) begin
        if (reset) begin
            add_r  <= '0;
            drdy_r <= 1'b0;
            drdy_q <= 1'b0;
        end else begin
            add_r  <= add;
            drdy_r <= drdy;
            drdy_q <= drdy_r;
        end
    end

    // A DRDY rising edge marks a slot start, so the phase restarts at 0 there.
    // Nothing is sampled while SYNC is held low.
    assign drdy_rise = drdy_r & ~drdy_q;
    assign phase_cur = drdy_rise ? '0 : phase;
    assign sample    = sync && (phase_cur == PW'(SAMPLE_PHASE));
    assign frame_end = sample && drdy_r;
    assign load      = frame_end && locked && (bitcnt == BITCNT_FULL);

    // Phase, bit count, lock, frame outcome pulses and the SYNC sequencer.
    // Entering the pulse is evaluated last so it overrides a same-cycle lock.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase     <= '0;
            bitcnt    <= '0;
            locked    <= 1'b0;
            ovalid    <= 1'b0;
            frame_err <= 1'b0;
            state     <= SYNC_IDLE;
            sync_cnt  <= '0;
            sync      <= 1'b1;
        end else begin
            phase     <= (phase_cur == PW'(CLKS_PER_BIT - 1)) ? '0 : phase_cur + PW'(1);
            ovalid    <= load;
            frame_err <= frame_end && locked && (bitcnt != BITCNT_FULL);

            if (frame_end) begin
                bitcnt <= '0;
                if (!locked) begin
                    locked <= 1'b1;
                end
            end else if (sample && (bitcnt != BITCNT_MAX)) begin
                bitcnt <= bitcnt + 6'd1;
            end

            case (state)
                SYNC_IDLE: begin
                    if (sync_req) begin
                        state    <= SYNC_PULSE;
                        sync     <= 1'b0;
                        sync_cnt <= '0;
                        locked   <= 1'b0;
                        bitcnt   <= '0;
                    end
                end
                SYNC_PULSE: begin
                    if (sync_cnt == SW'(SYNC_CLKS - 1)) begin
                        state <= SYNC_IDLE;
                        sync  <= 1'b1;
                    end else begin
                        sync_cnt <= sync_cnt + SW'(1);
                    end
                end
                default: begin
                    state <= SYNC_IDLE;
                    sync  <= 1'b1;
                end
            endcase
        end
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
`ifdef AD7768_RX_HDR_CHECK_EN
        ad7768_rx_lane #(.LANE(n)) u_lane (
`else
        ad7768_rx_lane u_lane (
`endif
            .clock   (clock),
            .reset   (reset),
            .sample  (sample),
            .load    (load),
            .bit_in  (add_r[n]),
            .data    (odata[DATA_BITS*n +: DATA_BITS]),
            .hdr_err (hdr_err[n])
        );
    end

endmodule

// File: tb/tb_ad7768_rx.sv
// Self-checking bench for ad7768_rx: drives framed AD7768 lane streams and
// compares every output, every cycle, against a frame-level model.
module tb_ad7768_rx;

    localparam int CPB       = 4;
    localparam int SYNC_CLKS = 8;
    localparam int LAT       = 4;

    logic         clock;
    logic         reset;
    logic [7:0]   add;
    logic         drdy;
    logic         sync_req;
    logic         sync;
    logic         ovalid;
    logic [191:0] odata;
    logic [7:0]   hdr_err;
    logic         frame_err;
    logic         locked;

    ad7768_rx dut (
        .clock     (clock),
        .reset     (reset),
        .add       (add),
        .drdy      (drdy),
        .sync_req  (sync_req),
        .sync      (sync),
        .ovalid    (ovalid),
        .odata     (odata),
        .hdr_err   (hdr_err),
        .frame_err (frame_err),
        .locked    (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int at;
        bit dr;
        int fid;
    } slot_t;

    slot_t        slot_q[$];
    slot_t        s_cur;
    logic [31:0]  fw_mem [256][8];
    int           fid;
    int           cyc;
    int           n_vec;
    int           n_mis;
    logic [15:0]  cnt16;

    int           m_cnt;
    int           m_sync_left;
    bit           m_locked;
    logic         exp_sync;
    logic         exp_locked;
    logic         exp_ovalid;
    logic         exp_ferr;
    logic [191:0] exp_data;
    logic [7:0]   exp_hdr;

    int           low_run;
    int           last_low;
    logic         prev_sync;
    logic         fall_locked;

    function automatic logic hdr_bad(input logic [31:0] w, input int n);
        logic [2:0] id;
        id = 3'(n);
        return (w[31:27] != 5'h10) || (w[26:24] != id) ||
               (w[23:19] != 5'h10) || (w[18:16] != id);
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one 32-bit word per lane, 4 clocks per bit, MSB first, DRDY in
    // the bit-0 slot. nslots=31 drops the bit-1 slot. pulse_bit/pulse_clk
    // place a one-cycle sync_req (kind 0) or reset (kind 1) inside the frame.
    task automatic applyStimulus(input int nslots, input int pulse_bit, input int pulse_clk,
                                 input int pulse_kind, input bit swap, input bit corrupt);
        logic [31:0] w [8];
        int fi;
        int src;
        fi = fid % 256;
        for (int ch = 0; ch < 8; ch++) begin
            w[ch] = {5'h10, 3'(ch), 5'h10, 3'(ch), cnt16};
            if (corrupt && ($urandom_range(0, 3) == 0))
                w[ch][31:16] = w[ch][31:16] ^ 16'($urandom_range(1, 65535));
        end
        for (int n = 0; n < 8; n++) begin
            src = n;
            if (swap && n == 2) src = 5;
            if (swap && n == 5) src = 2;
            fw_mem[fi][n] = w[src];
        end
        for (int b = 31; b >= 0; b--) begin
            if (nslots == 31 && b == 1) continue;
            for (int n = 0; n < 8; n++) add[n] = fw_mem[fi][n][b];
            drdy = (b == 0);
            slot_q.push_back('{cyc + LAT, (b == 0), fi});
            for (int c = 0; c < CPB; c++) begin
                sync_req = 1'b0;
                reset    = 1'b0;
                if (b == pulse_bit && c == pulse_clk) begin
                    if (pulse_kind == 0) sync_req = 1'b1;
                    else                 reset    = 1'b1;
                end
                @(posedge clock);
                #1;
            end
            sync_req = 1'b0;
            reset    = 1'b0;
        end
        fid++;
        cnt16 = cnt16 + 16'd1;
    endtask

    // Frame-level reference: at each DRDY sample decide lock / deliver /
    // frame error from the count of samples since the last frame end.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                m_locked = 0; m_cnt = 0; m_sync_left = 0;
                exp_sync = 1'b1; exp_locked = 1'b0; exp_ovalid = 1'b0; exp_ferr = 1'b0;
                exp_data = '0; exp_hdr = '0;
                while (slot_q.size() > 0 && slot_q[0].at <= cyc) void'(slot_q.pop_front());
            end else begin
                exp_ovalid = 1'b0;
                exp_ferr   = 1'b0;
                if (slot_q.size() > 0 && slot_q[0].at == cyc) begin
                    s_cur = slot_q.pop_front();
                    if (m_sync_left == 0) begin
                        if (s_cur.dr) begin
                            if (!m_locked) begin
                                m_locked = 1;
                            end else if (m_cnt == 31) begin
                                exp_ovalid = 1'b1;
                                for (int n = 0; n < 8; n++) begin
                                    exp_data[24*n +: 24] = fw_mem[s_cur.fid][n][23:0];
`ifdef AD7768_RX_HDR_CHECK_EN
                                    exp_hdr[n] = hdr_bad(fw_mem[s_cur.fid][n], n);
`else
                                    exp_hdr[n] = 1'b0;
`endif
                                end
                            end else begin
                                exp_ferr = 1'b1;
                            end
                            m_cnt = 0;
                        end else if (m_cnt < 63) begin
                            m_cnt++;
                        end
                    end
                end
                if (m_sync_left > 0) begin
                    m_sync_left--;
                end else if (sync_req) begin
                    m_sync_left = SYNC_CLKS;
                    m_locked    = 0;
                    m_cnt       = 0;
                end
                exp_sync   = (m_sync_left == 0);
                exp_locked = m_locked;
            end
        end
    end

    // Compare all outputs mid-cycle and measure SYNC low pulses
    initial begin
        low_run = 0; last_low = 0; prev_sync = 1'b1; fall_locked = 1'b1;
        forever begin
            @(negedge clock);
            if (cyc > 0) begin
                checkOutput("sync",      192'(sync),      192'(exp_sync));
                checkOutput("locked",    192'(locked),    192'(exp_locked));
                checkOutput("ovalid",    192'(ovalid),    192'(exp_ovalid));
                checkOutput("frame_err", 192'(frame_err), 192'(exp_ferr));
                checkOutput("odata",     odata,           exp_data);
                checkOutput("hdr_err",   192'(hdr_err),   192'(exp_hdr));
                if (prev_sync === 1'b1 && sync === 1'b0) fall_locked = locked;
                if (sync === 1'b0) low_run++;
                else if (low_run > 0) begin last_low = low_run; low_run = 0; end
                prev_sync = sync;
            end
        end
    end

    initial begin
        logic [15:0] c;
        int r;
        int pb;
        int pc;
        reset = 1'b1; add = '0; drdy = 1'b0; sync_req = 1'b0;
        cnt16 = 16'h1234; fid = 0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_sync",   192'(sync),   192'(1));
        checkOutput("rst_locked", 192'(locked), 192'(0));
        checkOutput("rst_ovalid", 192'(ovalid), 192'(0));
        checkOutput("rst_odata",  odata,        192'(0));
        reset = 1'b0;

        $display("[TB] free run");
        applyStimulus(32, -1, 0, 0, 0, 0);
        checkOutput("lock_locked", 192'(locked), 192'(1));
        checkOutput("lock_ovalid", 192'(ovalid), 192'(0));
        applyStimulus(32, -1, 0, 0, 0, 0);
        checkOutput("f2_ovalid", 192'(ovalid),        192'(1));
        checkOutput("f2_lane3",  192'(odata[72+:24]), 192'(24'h831235));
        checkOutput("f2_hdr",    192'(hdr_err),       192'(8'h00));
        applyStimulus(32, -1, 0, 0, 0, 0);
        checkOutput("f3_lane3",  192'(odata[72+:24]), 192'(24'h831236));
        repeat (3) applyStimulus(32, -1, 0, 0, 0, 0);

        $display("[TB] sync request");
        applyStimulus(32, 20, 0, 0, 0, 0);
        checkOutput("sync_width",  192'(last_low),    192'(8));
        checkOutput("sync_locked", 192'(fall_locked), 192'(0));
        checkOutput("sync_lockfr", 192'(ovalid),      192'(0));
        applyStimulus(32, -1, 0, 0, 0, 0);
        checkOutput("sync_resume", 192'(ovalid),      192'(1));

        $display("[TB] dropped slot");
        applyStimulus(31, -1, 0, 0, 0, 0);
        checkOutput("drop_ferr",   192'(frame_err), 192'(1));
        checkOutput("drop_ovalid", 192'(ovalid),    192'(0));
        applyStimulus(32, -1, 0, 0, 0, 0);
        checkOutput("drop_next",   192'(ovalid),    192'(1));

        $display("[TB] swapped lanes");
        repeat (2) begin
            c = cnt16;
            applyStimulus(32, -1, 0, 0, 1, 0);
`ifdef AD7768_RX_HDR_CHECK_EN
            checkOutput("swap_hdr", 192'(hdr_err), 192'(8'h24));
`else
            checkOutput("swap_hdr", 192'(hdr_err), 192'(8'h00));
`endif
            checkOutput("swap_lane2", 192'(odata[48+:24]), 192'({8'h85, c}));
        end

        $display("[TB] reset mid-frame");
        applyStimulus(32, 15, 0, 1, 0, 0);
        checkOutput("rstmid_locked", 192'(locked), 192'(1));
        checkOutput("rstmid_ovalid", 192'(ovalid), 192'(0));
        checkOutput("rstmid_odata",  odata,        192'(0));
        applyStimulus(32, -1, 0, 0, 0, 0);
        checkOutput("rstmid_next",   192'(ovalid), 192'(1));

        $display("[TB] sync on bit-0 sample");
        applyStimulus(32, 0, 3, 0, 0, 0);
        checkOutput("s0_ovalid", 192'(ovalid), 192'(1));
        checkOutput("s0_sync",   192'(sync),   192'(0));
        checkOutput("s0_locked", 192'(locked), 192'(0));
        applyStimulus(32, -1, 0, 0, 0, 0);
        checkOutput("s0_width",  192'(last_low), 192'(8));
        applyStimulus(32, -1, 0, 0, 0, 0);
        checkOutput("s0_resume", 192'(ovalid),   192'(1));

        $display("[TB] randomized frames");
        for (int i = 0; i < 16; i++) begin
            r  = $urandom_range(0, 7);
            pb = -1;
            pc = 0;
            if (r == 1) begin
                pb = $urandom_range(0, 31);
                pc = $urandom_range(0, CPB - 1);
            end
            cnt16 = 16'($urandom_range(0, 65535));
            applyStimulus((r == 0) ? 31 : 32, pb, pc, 0, 0, 1);
        end
        applyStimulus(32, -1, 0, 0, 0, 0);
        applyStimulus(32, -1, 0, 0, 0, 0);

        repeat (4) @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
